// File: rtl/fu_complete_arbiter_if.sv
// ---------------------------------------------------------------------------
// fu_complete_arbiter_if
//   Packet type shared by the functional units and the complete stage, and
//   the bus that connects the FU result ports and the complete-stage lanes
//   to fu_complete_arbiter.
//
//   fu_result_in    [NUM_FU]  one result per FU, qualified by .valid
//   fu_ready_out    [NUM_FU]  per-FU ready back to the FUs
//   complete_fu_out [WAYS]    registered packets to the complete stage
//   held_count                number of occupied holding slots
//
//   master: FU / complete-stage side (drives results, observes the rest)
//   slave : arbiter side
// ---------------------------------------------------------------------------
`ifndef SUPERSCALAR_WAYS
`define SUPERSCALAR_WAYS 3
`endif

package fu_complete_pkg;
  typedef struct packed {
    logic        valid;
    logic        take_branch;
    logic [5:0]  pr_idx;
    logic [4:0]  rob_idx;
    logic [31:0] value;
  } FU_COMPLETE_PACKET;
endpackage

interface fu_complete_arbiter_if
  import fu_complete_pkg::*;
#(
  parameter int NUM_FU = 5,
  parameter int WAYS   = `SUPERSCALAR_WAYS
);
  FU_COMPLETE_PACKET               fu_result_in    [NUM_FU];
  logic [NUM_FU-1:0]               fu_ready_out;
  FU_COMPLETE_PACKET               complete_fu_out [WAYS];
  logic [$clog2(NUM_FU+1)-1:0]     held_count;

  modport master (
    output fu_result_in,
    input  fu_ready_out,
    input  complete_fu_out,
    input  held_count
  );

  modport slave (
    input  fu_result_in,
    output fu_ready_out,
    output complete_fu_out,
    output held_count
  );
endinterface

// File: rtl/fu_complete_arbiter.sv
// ---------------------------------------------------------------------------
// fu_complete_arbiter
//   Collects results from NUM_FU functional units into one holding slot per
//   FU and forwards up to WAYS of them per cycle to the complete stage.
//   Taken branches go first, then everything else; each class is scanned
//   round-robin from r_rr_ptr. A slot that is granted can accept a new
//   result in the same cycle, so an uncontended FU streams one result per
//   cycle with a single cycle of latency.
//
//   clock   : sole clock, rising edge
//   reset   : synchronous, active-low; dominates squash
//   squash  : flush - drops every held result and zeroes the lanes
//   fu_bus  : slave side of fu_complete_arbiter_if
//             (fu_result_in, fu_ready_out, complete_fu_out, held_count)
// ---------------------------------------------------------------------------
`ifndef SUPERSCALAR_WAYS
`define SUPERSCALAR_WAYS 3
`endif

module fu_complete_arbiter
  import fu_complete_pkg::*;
#(
  parameter int NUM_FU = 5,
  parameter int WAYS   = `SUPERSCALAR_WAYS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   squash,
  fu_complete_arbiter_if.slave   fu_bus
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int CNT_W = $clog2(NUM_FU + 1);

  logic [NUM_FU-1:0]  r_hold_vld_p0;
  FU_COMPLETE_PACKET  r_hold_pkt_p0 [NUM_FU];
  logic [PTR_W-1:0]   r_rr_ptr;
  FU_COMPLETE_PACKET  r_lane_p1 [WAYS];

  logic [NUM_FU-1:0]  w_grant;
  logic [NUM_FU-1:0]  w_ready;
  logic [NUM_FU-1:0]  w_accept;
  logic [WAYS-1:0]    w_lane_vld;
  logic [PTR_W-1:0]   w_lane_sel [WAYS];
  logic               w_nb_any;
  logic [PTR_W-1:0]   w_nb_last;
  logic [PTR_W-1:0]   w_rr_next;
  logic [CNT_W-1:0]   w_held_count;

  // (base + off) mod NUM_FU for off < NUM_FU; the sum never exceeds
  // 2*(NUM_FU-1), so one conditional subtract is enough.
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                input int              off);
    logic [PTR_W:0] s;
    s = {1'b0, base} + (PTR_W+1)'(off);
    if (s >= (PTR_W+1)'(NUM_FU)) s = s - (PTR_W+1)'(NUM_FU);
    return s[PTR_W-1:0];
  endfunction

  // Two passes over the ring starting at r_rr_ptr: pass 0 picks taken
  // branches, pass 1 the rest. Each winner takes the lowest free lane, so
  // lane order equals priority order.
  always_comb begin : arb
    logic [PTR_W-1:0] idx;
    logic             placed;
    logic             want_br;
    idx        = '0;
    placed     = 1'b0;
    want_br    = 1'b0;
    w_grant    = '0;
    w_lane_vld = '0;
    w_nb_any   = 1'b0;
    w_nb_last  = '0;
    for (int k = 0; k < WAYS; k++) w_lane_sel[k] = '0;
    for (int pass = 0; pass < 2; pass++) begin
      want_br = (pass == 0);
      for (int j = 0; j < NUM_FU; j++) begin
        idx    = wrap_idx(r_rr_ptr, j);
        placed = 1'b0;
        if (r_hold_vld_p0[idx] && (r_hold_pkt_p0[idx].take_branch == want_br)) begin
          for (int k = 0; k < WAYS; k++) begin
            if (!placed && !w_lane_vld[k]) begin
              w_lane_vld[k] = 1'b1;
              w_lane_sel[k] = idx;
              placed        = 1'b1;
            end
          end
          if (placed) begin
            w_grant[idx] = 1'b1;
            if (!want_br) begin
              w_nb_any  = 1'b1;
              w_nb_last = idx;
            end
          end
        end
      end
    end
  end

  assign w_rr_next = w_nb_any ? wrap_idx(w_nb_last, 1) : r_rr_ptr;

  // A slot can take a new result when it is empty or draining this cycle;
  // reset and squash both close every input.
  always_comb begin
    w_ready  = '0;
    w_accept = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      w_ready[i]  = (~r_hold_vld_p0[i] | w_grant[i]) & ~squash & reset;
      w_accept[i] = fu_bus.fu_result_in[i].valid & w_ready[i];
    end
  end

  always_comb begin
    w_held_count = '0;
    for (int i = 0; i < NUM_FU; i++) w_held_count = w_held_count + CNT_W'(r_hold_vld_p0[i]);
  end

  // ---- p0: holding slots, round-robin pointer, output lanes (p1) ----
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_hold_vld_p0 <= '0;
      r_rr_ptr      <= '0;
      for (int k = 0; k < WAYS; k++) r_lane_p1[k] <= '0;
    end else if (squash) begin
      r_hold_vld_p0 <= '0;
      for (int k = 0; k < WAYS; k++) r_lane_p1[k] <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_accept[i])     r_hold_vld_p0[i] <= 1'b1;
        else if (w_grant[i]) r_hold_vld_p0[i] <= 1'b0;
      end
      r_rr_ptr <= w_rr_next;
      for (int k = 0; k < WAYS; k++)
        r_lane_p1[k] <= w_lane_vld[k] ? r_hold_pkt_p0[w_lane_sel[k]] : '0;
    end
  end

  // Slot payload needs no reset: it is only ever read behind r_hold_vld_p0.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++)
      if (w_accept[i]) r_hold_pkt_p0[i] <= fu_bus.fu_result_in[i];
  end

  assign fu_bus.fu_ready_out    = w_ready;
  assign fu_bus.complete_fu_out = r_lane_p1;
  assign fu_bus.held_count      = w_held_count;

endmodule

// File: tb/tb_fu_complete_arbiter.sv
module tb_fu_complete_arbiter;
  import fu_complete_pkg::*;

  localparam int N = 5;
  localparam int W = 3;

  logic clock;
  logic reset;
  logic squash;

  fu_complete_arbiter_if #(.NUM_FU(N), .WAYS(W)) ifc ();
  fu_complete_arbiter_if #(.NUM_FU(N), .WAYS(1)) ifc1 ();

  fu_complete_arbiter #(.NUM_FU(N), .WAYS(W)) u_dut (
    .clock (clock),
    .reset (reset),
    .squash(squash),
    .fu_bus(ifc)
  );

  fu_complete_arbiter #(.NUM_FU(N), .WAYS(1)) u_dut1 (
    .clock (clock),
    .reset (reset),
    .squash(squash),
    .fu_bus(ifc1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string                      nm;
    FU_COMPLETE_PACKET [W-1:0]  lanes;
  } exp_t;

  exp_t sb[$];
  FU_COMPLETE_PACKET z;

  function automatic FU_COMPLETE_PACKET pk(input bit br, input int pr);
    FU_COMPLETE_PACKET p;
    p             = '0;
    p.valid       = 1'b1;
    p.take_branch = br;
    p.pr_idx      = 6'(pr);
    p.rob_idx     = 5'(pr);
    p.value       = 32'(pr * 1000 + 7);
    return p;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_lanes_zero(input string nm);
    for (int k = 0; k < W; k++) chk(nm, 64'(ifc.complete_fu_out[k]), 64'(0));
  endtask

  task automatic push_exp(input string nm, input FU_COMPLETE_PACKET a,
                          input FU_COMPLETE_PACKET b, input FU_COMPLETE_PACKET c);
    exp_t e;
    e.nm       = nm;
    e.lanes[0] = a;
    e.lanes[1] = b;
    e.lanes[2] = c;
    sb.push_back(e);
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) begin
      ifc.fu_result_in[i]  = '0;
      ifc1.fu_result_in[i] = '0;
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: whenever the wide DUT presents any valid lane, pop one expected
  // cycle from the scoreboard and compare every lane.
  always @(negedge clock) begin
    bit   any;
    exp_t e;
    any = 1'b0;
    for (int k = 0; k < W; k++) if (ifc.complete_fu_out[k].valid) any = 1'b1;
    if (any) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: lane0 got %h, expected no output",
                 ifc.complete_fu_out[0]);
      end else begin
        e = sb.pop_front();
        for (int k = 0; k < W; k++) begin
          n_checks++;
          if (ifc.complete_fu_out[k] !== e.lanes[k]) begin
            n_fail++;
            $display("FAIL %s lane%0d: got %h expected %h", e.nm, k,
                     ifc.complete_fu_out[k], e.lanes[k]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen [N];
    int p;
    z = '0;
    reset  = 1'b0;
    squash = 1'b0;
    clr();

    // Reset: everything zero, inputs ignored
    step();
    step();
    ifc.fu_result_in[0] = pk(0, 1);
    #1;
    chk("rst_ready", 64'(ifc.fu_ready_out), 64'(0));
    step();
    chk("rst_held", 64'(ifc.held_count), 64'(0));
    chk_lanes_zero("rst_lanes");
    clr();
    reset = 1'b1;
    #1;
    chk("idle_ready", 64'(ifc.fu_ready_out), 64'h1f);

    // Oversubscription: all five FUs at once, rr_ptr = 0
    for (int i = 0; i < N; i++) ifc.fu_result_in[i] = pk(0, 10 + i);
    push_exp("ovs_c1", pk(0, 10), pk(0, 11), pk(0, 12));
    push_exp("ovs_c2", pk(0, 13), pk(0, 14), z);
    step();
    clr();
    #1;
    chk("ovs_held5", 64'(ifc.held_count), 64'(5));
    chk("ovs_ready_c1", 64'(ifc.fu_ready_out), 64'h07);
    step();
    chk("ovs_held2", 64'(ifc.held_count), 64'(2));
    chk("ovs_ready_c2", 64'(ifc.fu_ready_out), 64'h1f);
    step();
    chk("ovs_held0", 64'(ifc.held_count), 64'(0));

    // Branch priority: FU4 taken branch; FU0 reloads in the granted cycle.
    // rr_ptr becomes 2, so the second cycle order is FU2, FU3, FU0.
    for (int i = 0; i < 4; i++) ifc.fu_result_in[i] = pk(0, 20 + i);
    ifc.fu_result_in[4] = pk(1, 24);
    push_exp("br_c1", pk(1, 24), pk(0, 20), pk(0, 21));
    push_exp("br_c2", pk(0, 22), pk(0, 23), pk(0, 30));
    step();
    clr();
    ifc.fu_result_in[0] = pk(0, 30);
    #1;
    chk("br_ready", 64'(ifc.fu_ready_out), 64'h13);
    step();
    clr();
    #1;
    chk("br_held3", 64'(ifc.held_count), 64'(3));
    step();
    chk("br_held0", 64'(ifc.held_count), 64'(0));

    // Single result on FU2
    ifc.fu_result_in[2] = pk(0, 7);
    push_exp("single", pk(0, 7), z, z);
    step();
    clr();
    #1;
    chk("single_held1", 64'(ifc.held_count), 64'(1));
    step();
    chk("single_held0", 64'(ifc.held_count), 64'(0));

    // Throughput: FU1 streams one result per cycle
    for (int n = 0; n < 4; n++) begin
      ifc.fu_result_in[1] = pk(0, 40 + n);
      #1;
      chk("thr_ready", 64'(ifc.fu_ready_out[1]), 64'(1));
      push_exp("thr", pk(0, 40 + n), z, z);
      step();
    end
    clr();
    step();
    step();

    // Squash with four held slots; rr_ptr (2) must survive
    for (int i = 0; i < 4; i++) ifc.fu_result_in[i] = pk(0, 50 + i);
    step();
    clr();
    squash = 1'b1;
    #1;
    chk("sq_held4", 64'(ifc.held_count), 64'(4));
    chk("sq_ready", 64'(ifc.fu_ready_out), 64'(0));
    step();
    squash = 1'b0;
    #1;
    chk("sq_held0", 64'(ifc.held_count), 64'(0));
    chk_lanes_zero("sq_lanes");
    chk("sq_ready_after", 64'(ifc.fu_ready_out), 64'h1f);
    for (int i = 0; i < 4; i++) ifc.fu_result_in[i] = pk(0, 60 + i);
    push_exp("post_sq_c1", pk(0, 62), pk(0, 63), pk(0, 60));
    push_exp("post_sq_c2", pk(0, 61), z, z);
    step();
    clr();
    step();
    step();

    // Reset mid-stream: lanes busy, three slots held, rr_ptr = 1
    for (int i = 0; i < 4; i++) ifc.fu_result_in[i] = pk(0, 1 + i);
    push_exp("mid_c1", pk(0, 3), pk(0, 4), pk(0, 1));
    step();
    clr();
    ifc.fu_result_in[3] = pk(0, 5);
    ifc.fu_result_in[2] = pk(0, 6);
    #1;
    chk("mid_ready", 64'(ifc.fu_ready_out), 64'h1d);
    step();
    clr();
    reset = 1'b0;
    #1;
    chk("mid_held3", 64'(ifc.held_count), 64'(3));
    chk("mid_ready_rst", 64'(ifc.fu_ready_out), 64'(0));
    step();
    chk_lanes_zero("mid_lanes");
    chk("mid_held0", 64'(ifc.held_count), 64'(0));
    ifc.fu_result_in[1] = pk(0, 8);
    #1;
    chk("mid_ready_rst2", 64'(ifc.fu_ready_out), 64'(0));
    step();
    chk("mid_ignored", 64'(ifc.held_count), 64'(0));
    chk_lanes_zero("mid_lanes2");
    clr();
    reset = 1'b1;
    #1;
    chk("mid_ready_after", 64'(ifc.fu_ready_out), 64'h1f);
    for (int i = 0; i < 4; i++) ifc.fu_result_in[i] = pk(0, 32 + i);
    push_exp("post_rst_c1", pk(0, 32), pk(0, 33), pk(0, 34));
    push_exp("post_rst_c2", pk(0, 35), z, z);
    step();
    clr();
    step();
    step();

    // Fairness on the single-lane instance: FU0/FU1 always valid,
    // FU2-FU4 loaded once; they drain on cycles 3, 4, 5.
    for (int i = 0; i < N; i++) seen[i] = -1;
    for (int c = 0; c < 10; c++) begin
      ifc1.fu_result_in[0] = pk(0, 44);
      ifc1.fu_result_in[1] = pk(0, 45);
      for (int i = 2; i < N; i++) ifc1.fu_result_in[i] = (c == 0) ? pk(0, 44 + i) : z;
      step();
      if (ifc1.complete_fu_out[0].valid) begin
        p = int'(ifc1.complete_fu_out[0].pr_idx) - 44;
        if (p >= 0 && p < N && seen[p] < 0) seen[p] = c;
      end
    end
    clr();
    chk("fair_fu0", 64'(seen[0]), 64'(1));
    chk("fair_fu2", 64'(seen[2]), 64'(3));
    chk("fair_fu3", 64'(seen[3]), 64'(4));
    chk("fair_fu4", 64'(seen[4]), 64'(5));
    step();
    step();

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
